dii_packet_buffer: RTL and testbench
====================================

// Module: dii_packet_buffer
// PURPOSE
//  Packet-aware DII flit FIFO. It sits between debug_system ring_out and the
//  per-core debug ring segment, and likewise on the return path into ring_in.
//  It decouples ring timing across the SoC and forwards only complete packets
//  downstream, so a partially received packet never stalls the next ring hop.
//  One instance per ring direction.
// PARAMETERS
//  DEPTH        16  flit entries; power of 2, >= 2; must be >= MAX_PKT_LEN
//  FULLPACKET   1   1: release a packet only once its last flit is stored;
//                   0: plain flit FIFO
// PORTS
//  clk             in   1          single clock
//  rstn            in   1          asynchronous, active-low reset
//  flit_in         in   dii_flit   {valid,last,data[15:0]} from upstream
//  flit_in_ready   out  1          accept; a transfer is flit_in.valid & flit_in_ready
//  flit_out        out  dii_flit   to downstream ring hop
//  flit_out_ready  in   1          downstream accept
//  pkt_count       out  $clog2(DEPTH)+1  complete packets currently stored
// BEHAVIOUR
//  Reset (rstn low, async): wr_ptr=rd_ptr=0, pkt_count=0, escape=0,
//   flit_out.valid=0, flit_in_ready=0. flit_in_ready=1 in first cycle after.
//  Pointers: $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
//   empty = (wr_ptr==rd_ptr); full = MSBs differ & rest equal.
//  Storage: DEPTH x {last,data} registers; valid is not stored.
//  flit_in_ready = !full. A push writes mem[wr_ptr], wr_ptr++.
//  flit_out.data/last = mem[rd_ptr] (comb from regs); latency 1 cycle min
//   (pushed at edge N, visible after edge N, pop possible at edge N+1).
//  flit_out.valid: FULLPACKET=0 -> !empty;
//   FULLPACKET=1 -> !empty & (pkt_count!=0 | escape).
//   Pop = valid & flit_out_ready; rd_ptr++.
//  pkt_count: +1 on push with last=1, -1 on pop with last=1,
//   net 0 when both happen in the same cycle; never wraps (bounded by DEPTH).
//  Escape (FULLPACKET=1, protects against oversize packets): set when
//   full & pkt_count==0; cleared on pop of a flit with last=1. While set,
//   flits stream out as in FULLPACKET=0.
//   pkt_count is not decremented for the escaped packet's last flit, because
//   that packet was never counted complete. This holds only while the
//   packet's last has not yet been pushed. If its last is pushed while
//   escape=1, that push does not increment pkt_count.
//  Simultaneous push & pop when full: illegal push (ready=0); pop proceeds.
//  When empty, push and pop in the same cycle are impossible (no bypass path).
//  flit_out.valid, once asserted, holds with stable data until popped
//   (AXI-style), including across escape clear.
//  Reset mid-packet discards all stored flits; no partial flit emitted after.
// STRUCTURE
//  dii_flit comes from dii_package. Add to dii_package:
//   localparam DII_DATA_W = 16.
//  Single module; storage is inline registers (no RAM macro).
//  No sub-module needed; pointer/flag logic ~150 lines.
// TESTING
//  1 FULLPACKET=1, push 3 flits, last on 3rd, ready=1 -> out.valid stays 0
//    until cycle after 3rd push; then 3 pops, pkt_count 1->0.
//  2 Push 16 flits, no last, DEPTH=16 -> full, in_ready=0, escape=1,
//    flits 0..15 drain in order.
//    Then push 1 flit, last=1 -> pops; escape=0, pkt_count=0.
//  3 Back-to-back 2-flit packets, out_ready=1 constant -> 1 flit/cycle steady
//    state; pkt_count never exceeds 2.
//  4 Push last-flit and pop last-flit in the same cycle -> pkt_count unchanged.
//  5 Random out_ready stalls while flit_out.valid -> data/last stable until
//    pop; ordering matches scoreboard for 1000 random packets of length 1..16.
//  6 Assert rstn low mid-packet (5 flits stored) -> flit_out.valid=0
//    immediately; after release pkt_count=0, empty, in_ready=1.
//    FULLPACKET=0 regression: a single flit without last is visible at the
//    output 1 cycle after push.

Source files
------------

// File: rtl/dii_package.sv
// dii_package: shared DII ring flit type and data width.
package dii_package;
    localparam int DII_DATA_W = 16;
    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DII_DATA_W-1:0] data;
    } dii_flit;
endpackage

// File: rtl/dii_packet_buffer.sv
// dii_packet_buffer: packet-aware DII flit FIFO that forwards only complete
// packets downstream, with an escape path for packets larger than the buffer.
module dii_packet_buffer
    import dii_package::*;
#(
    parameter int DEPTH      = 16,
    parameter int FULLPACKET = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  dii_flit                  flit_in,
    output logic                     flit_in_ready,
    output dii_flit                  flit_out,
    input  logic                     flit_out_ready,
    output logic [$clog2(DEPTH):0]   pkt_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         pkt_count_q, pkt_count_d;
    logic                  escape_q, escape_d;
    logic                  esc_last_q, esc_last_d;
    logic                  init_q, init_d;
    logic [DII_DATA_W:0]   mem_q [DEPTH];
    logic [DII_DATA_W:0]   head;
    logic                  empty, full, out_valid, push, pop, cnt_inc, cnt_dec;

    always_comb begin
        empty         = wr_ptr_q == rd_ptr_q;
        full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        init_d        = 1'b1;
        flit_in_ready = init_q & ~full;
        head          = mem_q[rd_ptr_q[AW-1:0]];
        out_valid     = (FULLPACKET != 0) ? (!empty && (pkt_count_q != '0 || escape_q)) : !empty;
        flit_out      = {out_valid, head};
        push          = flit_in.valid & flit_in_ready;
        pop           = out_valid & flit_out_ready;
        // The oversize packet being escaped was never counted complete, so its
        // last flit neither increments on push nor decrements on pop.
        cnt_inc       = push & flit_in.last & ~(escape_q & ~esc_last_q);
        cnt_dec       = pop & head[DII_DATA_W] & ~escape_q;
        pkt_count_d   = pkt_count_q + PW'(cnt_inc) - PW'(cnt_dec);
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        escape_d      = (FULLPACKET != 0) &&
                        (escape_q ? !(pop && head[DII_DATA_W]) : (full && pkt_count_q == '0));
        esc_last_d    = escape_q & escape_d & (esc_last_q | (push & flit_in.last));
        pkt_count     = pkt_count_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            escape_q    <= 1'b0;
            esc_last_q  <= 1'b0;
            init_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            escape_q    <= escape_d;
            esc_last_q  <= esc_last_d;
            init_q      <= init_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {flit_in.last, flit_in.data};
    end
endmodule

// File: tb/tb_dii_packet_buffer.sv
// tb_dii_packet_buffer: table vectors, directed corner sequences and a random
// scoreboard run against a queue-based reference of the packet buffer.
module tb_dii_packet_buffer;
    import dii_package::*;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic in0_valid = 1'b0, in0_last = 1'b0, out0_ready = 1'b0;
    logic [15:0] in0_data = '0;
    dii_flit fi, fo, fi0, fo0;
    logic fi_rdy, fi0_rdy;
    logic [4:0] cnt, cnt0;
    int total = 0, bad = 0;

    assign fi  = {in_valid, in_last, in_data};
    assign fi0 = {in0_valid, in0_last, in0_data};

    always #5 clk = ~clk;

    dii_packet_buffer #(.DEPTH(DEPTH), .FULLPACKET(1)) dut (
        .clk(clk), .rstn(rstn), .flit_in(fi), .flit_in_ready(fi_rdy),
        .flit_out(fo), .flit_out_ready(out_ready), .pkt_count(cnt));

    dii_packet_buffer #(.DEPTH(DEPTH), .FULLPACKET(0)) dut0 (
        .clk(clk), .rstn(rstn), .flit_in(fi0), .flit_in_ready(fi0_rdy),
        .flit_out(fo0), .flit_out_ready(out0_ready), .pkt_count(cnt0));

    // Reference: stored flits as {last,data}; escape flag; ready after first edge.
    logic [16:0] q[$];
    bit esc = 0, m_init = 0;

    function automatic int m_cnt();
        int n = 0;
        foreach (q[i]) n += int'(q[i][16]);
        return (esc && n > 0) ? n - 1 : n;
    endfunction
    function automatic bit m_valid();
        return q.size() > 0 && (m_cnt() > 0 || esc);
    endfunction
    function automatic bit m_ready();
        return m_init && q.size() < DEPTH;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic mchk(input string tag);
        chk({tag, "_ready"}, 32'(fi_rdy), 32'(m_ready()));
        chk({tag, "_valid"}, 32'(fo.valid), 32'(m_valid()));
        chk({tag, "_cnt"}, 32'(cnt), 32'(m_cnt()));
        if (m_valid()) begin
            chk({tag, "_data"}, 32'(fo.data), 32'(q[0][15:0]));
            chk({tag, "_last"}, 32'(fo.last), 32'(q[0][16]));
        end
    endtask

    task automatic tick(output bit pushed);
        bit pop;
        int sz, c;
        logic [16:0] popped;
        pushed = in_valid && m_ready();
        pop = m_valid() && out_ready;
        sz = q.size();
        c = m_cnt();
        popped = '0;
        @(posedge clk);
        #1;
        if (!rstn) begin
            pushed = 0;
            return;
        end
        if (pop) popped = q.pop_front();
        if (pushed) q.push_back({in_last, in_data});
        if (esc) begin
            if (pop && popped[16]) esc = 0;
        end else if (sz == DEPTH && c == 0) esc = 1;
        m_init = 1;
    endtask

    task automatic cyc(input logic v, input logic l, input logic [15:0] d, input logic r, input string tag);
        bit p;
        in_valid = v; in_last = l; in_data = d; out_ready = r;
        mchk(tag);
        tick(p);
    endtask

    typedef struct {
        logic iv, il; logic [15:0] id; logic ordy;
        logic ev, el; logic [15:0] ed; logic [4:0] ec;
    } vec_t;
    vec_t tbl[11];

    initial begin
        bit p;
        logic [16:0] stream[$];
        int cycles;
        tbl[0]  = '{1, 0, 16'hA001, 1, 0, 0, 16'h0,    0};
        tbl[1]  = '{1, 0, 16'hA002, 1, 0, 0, 16'h0,    0};
        tbl[2]  = '{1, 1, 16'hA003, 1, 0, 0, 16'h0,    0};
        tbl[3]  = '{0, 0, 16'h0,    1, 1, 0, 16'hA001, 1};
        tbl[4]  = '{0, 0, 16'h0,    1, 1, 0, 16'hA002, 1};
        tbl[5]  = '{0, 0, 16'h0,    1, 1, 1, 16'hA003, 1};
        tbl[6]  = '{1, 1, 16'hC001, 1, 0, 0, 16'h0,    0};
        tbl[7]  = '{1, 1, 16'hD001, 1, 1, 1, 16'hC001, 1};
        tbl[8]  = '{0, 0, 16'h0,    0, 1, 1, 16'hD001, 1};
        tbl[9]  = '{0, 0, 16'h0,    1, 1, 1, 16'hD001, 1};
        tbl[10] = '{0, 0, 16'h0,    0, 0, 0, 16'h0,    0};

        #12;
        chk("rst_ready", 32'(fi_rdy), 0);
        chk("rst_valid", 32'(fo.valid), 0);
        chk("rst_cnt", 32'(cnt), 0);
        @(posedge clk); #1 rstn = 1'b1;
        tick(p);
        chk("post_rst_ready", 32'(fi_rdy), 1);

        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; in_last = tbl[i].il; in_data = tbl[i].id; out_ready = tbl[i].ordy;
            chk($sformatf("tbl%0d_valid", i), 32'(fo.valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].ec));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_data", i), 32'(fo.data), 32'(tbl[i].ed));
                chk($sformatf("tbl%0d_last", i), 32'(fo.last), 32'(tbl[i].el));
            end
            tick(p);
        end

        for (int i = 0; i < 20; i++) begin
            if (i >= 2) chk("t3_steady_valid", 32'(fo.valid), 1);
            chk("t3_cnt_le2", 32'(cnt <= 2), 1);
            cyc(1'b1, 1'(i % 2), 16'(16'h3000 + i), 1'b1, "t3");
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1, "t3d");

        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 16'(i), 1'b0, "t2fill");
        chk("t2_full_ready", 32'(fi_rdy), 0);
        chk("t2_pre_esc_valid", 32'(fo.valid), 0);
        cyc(1'b1, 1'b0, 16'hFFFF, 1'b0, "t2full");
        chk("t2_esc_valid", 32'(fo.valid), 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_order", 32'(fo.data), 32'(i));
            cyc(1'b0, 1'b0, '0, 1'b1, "t2drain");
        end
        cyc(1'b1, 1'b1, 16'h00EE, 1'b1, "t2last");
        chk("t2_last_valid", 32'(fo.valid & fo.last), 1);
        chk("t2_last_cnt", 32'(cnt), 0);
        cyc(1'b0, 1'b0, '0, 1'b1, "t2pop");
        cyc(1'b1, 1'b0, 16'h0077, 1'b1, "t2post");
        cyc(1'b0, 1'b0, '0, 1'b1, "t2post");
        chk("t2_esc_cleared", 32'(fo.valid), 0);
        cyc(1'b1, 1'b1, 16'h0078, 1'b1, "t2fin");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, "t2fin");

        for (int pk = 0; pk < 1000; pk++) begin
            int len = int'($urandom_range(1, 16));
            for (int j = 0; j < len; j++) stream.push_back({j == len - 1, 16'($urandom)});
        end
        cycles = 0;
        while ((stream.size() > 0 || q.size() > 0) && cycles < 60000) begin
            in_valid = stream.size() > 0 && ($urandom % 4 != 0);
            {in_last, in_data} = stream.size() > 0 ? stream[0] : 17'h0;
            out_ready = ($urandom % 4) != 0;
            mchk("t5");
            tick(p);
            if (p) void'(stream.pop_front());
            cycles++;
        end
        chk("t5_timeout", 32'(cycles < 60000), 1);

        cyc(1'b1, 1'b1, 16'h0051, 1'b0, "t6");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'(16'h0060 + i), 1'b0, "t6");
        in_valid = 1'b0;
        chk("t6_pre_valid", 32'(fo.valid), 1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(fo.valid), 0);
        chk("t6_rst_ready", 32'(fi_rdy), 0);
        chk("t6_rst_cnt", 32'(cnt), 0);
        q.delete(); esc = 0; m_init = 0;
        tick(p);
        rstn = 1'b1;
        tick(p);
        mchk("t6_after");
        chk("t6_after_ready", 32'(fi_rdy), 1);
        cyc(1'b0, 1'b0, '0, 1'b1, "t6_idle");

        chk("fp0_pre_valid", 32'(fo0.valid), 0);
        in0_valid = 1'b1; in0_last = 1'b0; in0_data = 16'h0ABC;
        @(posedge clk); #1;
        in0_valid = 1'b0;
        chk("fp0_valid", 32'(fo0.valid), 1);
        chk("fp0_data", 32'(fo0.data), 32'h0ABC);
        chk("fp0_last", 32'(fo0.last), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
